// File: rtl/display_mux.sv
// Time-multiplexes two synchronized hex digits onto one segment bus,
// with blanking gaps between digits and active-low anode enables.
module display_mux #(
  parameter int HOLD_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 480,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s,
  output logic       an0,
  output logic       an1,
  output logic       digit
);

  // Gray-coded so every legal transition flips one bit and the decoded
  // anode/digit outputs cannot glitch between states.
  typedef enum logic [1:0] {
    SHOW0  = 2'b00,
    BLANK0 = 2'b01,
    SHOW1  = 2'b11,
    BLANK1 = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'(BLANK_CYCLES - 1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next, last;
  logic [3:0]           s0_meta, s0_sync, s1_meta, s1_sync, s_next;
  logic                 advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_meta <= 4'h0;
      s0_sync <= 4'h0;
      s1_meta <= 4'h0;
      s1_sync <= 4'h0;
    end else begin
      s0_meta <= s0;
      s0_sync <= s0_meta;
      s1_meta <= s1;
      s1_sync <= s1_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BLANK1;
      cnt   <= '0;
      s     <= 4'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      s     <= s_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_WIDTH'(1);
    s_next     = s;
    last       = ((state == SHOW0) || (state == SHOW1)) ? HOLD_LAST : BLANK_LAST;
    advance    = (cnt >= last);
    if (advance) cnt_next = '0;
    case (state)
      SHOW0:  if (advance) state_next = BLANK0;
      BLANK0: if (advance) begin
        state_next = SHOW1;
        s_next     = s1_sync;
      end
      SHOW1:  if (advance) state_next = BLANK1;
      BLANK1: if (advance) begin
        state_next = SHOW0;
        s_next     = s0_sync;
      end
      default: begin
        state_next = BLANK1;
        cnt_next   = '0;
      end
    endcase
  end

  assign an0   = (state != SHOW0);
  assign an1   = (state != SHOW1);
  assign digit = (state == SHOW1) || (state == BLANK1);

endmodule
